writeback_block: RTL

- Write-back path of the L1 set-associative LRU cache.
- Takes a dirty victim block chosen by the cache controller and writes it, one byte per cycle, into the byte-wide block-RAM main memory at the victim's address.
- It is the writer counterpart of the miss-fill reader. It uses the same address composition {tag, index, byte_offset}, the same byte order (byte j at block[8j+7:8j]), and reports its cycle cost for the simulator's latency accounting.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/writeback_block.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared L1 cache definitions: parameter defaults, derived field widths and the
// state encoding used by the write-back and miss-fill engines.
package cache_pkg;

    localparam int WAY             = 4;
    localparam int BLOCK_SIZE_BYTE = 16;
    localparam int CACHE_SIZE_BYTE = 32768;
    localparam int ADDR_W          = 16;
    localparam int LAT_W           = 8;

    localparam int OFFSET_W = $clog2(BLOCK_SIZE_BYTE);
    localparam int SET      = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY);
    localparam int INDEX_W  = $clog2(SET);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/writeback_block.sv
// Write-back engine: streams a dirty victim block, one byte per cycle, into the
// byte-wide main memory at {tag, index, offset} and accounts its cycle cost.
module writeback_block #(
    parameter int WAY             = cache_pkg::WAY,
    parameter int BLOCK_SIZE_BYTE = cache_pkg::BLOCK_SIZE_BYTE,
    parameter int CACHE_SIZE_BYTE = cache_pkg::CACHE_SIZE_BYTE,
    parameter int ADDR_W          = cache_pkg::ADDR_W,
    parameter int LAT_W           = cache_pkg::LAT_W,
    localparam int OFFSET_W       = $clog2(BLOCK_SIZE_BYTE),
    localparam int SET            = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    localparam int INDEX_W        = $clog2(SET),
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W,
    localparam int BLOCK_W        = BLOCK_SIZE_BYTE * 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               trace_ready,
    input  logic [TAG_W-1:0]   tag,
    input  logic [INDEX_W-1:0] index,
    input  logic [BLOCK_W-1:0] block,
    output logic               busy,
    output logic               done,
    output logic [LAT_W-1:0]   wb_latency,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [7:0]         mem_din
);

    import cache_pkg::*;

    localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(BLOCK_SIZE_BYTE - 1);

    wb_state_t            state_q, state_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [BLOCK_W-1:0]   shreg_q, shreg_d;
    logic [OFFSET_W-1:0]  cnt_q, cnt_d, cnt_next;
    logic                 busy_d, done_d, mem_en_d, mem_we_d;
    logic [LAT_W-1:0]     lat_d;
    logic [ADDR_W-1:0]    mem_addr_d;
    logic [7:0]           mem_din_d;

    // Latency accounting saturates at all-ones instead of wrapping.
    function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    assign cnt_next = cnt_q + OFFSET_W'(1);

    // The bus outputs are registered, so byte 0 is loaded onto mem_din at the
    // acceptance edge and shreg holds only the bytes still to be presented.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        tag_d      = tag_q;
        index_d    = index_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        busy_d     = busy;
        done_d     = done;
        mem_en_d   = mem_en;
        mem_we_d   = mem_we;
        lat_d      = wb_latency;
        mem_addr_d = mem_addr;
        mem_din_d  = mem_din;

        unique case (state_q)
            IDLE: begin
                busy_d   = 1'b0;
                done_d   = 1'b0;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (trace_ready) lat_d = '0;
                if (start) begin
                    tag_d      = tag;
                    index_d    = index;
                    shreg_d    = block >> 8;
                    cnt_d      = '0;
                    mem_addr_d = {tag, index, {OFFSET_W{1'b0}}};
                    mem_din_d  = block[7:0];
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    busy_d     = 1'b1;
                    lat_d      = lat_inc(trace_ready ? '0 : wb_latency);
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                lat_d = lat_inc(wb_latency);
                cnt_d = cnt_next;
                if (cnt_q == LAST_OFFSET) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    mem_addr_d = {tag_q, index_q, cnt_next};
                    mem_din_d  = shreg_q[7:0];
                    shreg_d    = shreg_q >> 8;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d   = 1'b0;
                done_d   = 1'b0;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            index_q    <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            wb_latency <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            busy       <= busy_d;
            done       <= done_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            wb_latency <= lat_d;
            mem_addr   <= mem_addr_d;
            mem_din    <= mem_din_d;
        end
    end

endmodule
